ipf: RTL and testbench

//  3x3 convolution engine: buffers an 8x8 image of unsigned 8-bit pixels and a 3x3 signed 8-bit kernel, then computes all 36 valid-region outputs.

---
 rtl/ipf_pkg.sv | 31 +++
 rtl/ipf_if.sv | 25 ++
 rtl/ipf_row_mac.sv | 30 +++
 rtl/ipf.sv | 155 +++++++++++++++
 tb/tb_ipf.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ipf_pkg.sv
// Shared types and constants for the ipf 3x3 convolution engine.
// Imported by the interface, the row MAC and the top.
package ipf_pkg;

   localparam int IMG_DIM = 8;
   localparam int K_DIM   = 3;
   localparam int OUT_DIM = 6;
   localparam int ACC_W   = 32;
   localparam int PIX_W   = 8;
   localparam int TAPS    = K_DIM * K_DIM;
   localparam int ROW_W   = IMG_DIM * PIX_W;
   localparam int OROW_W  = OUT_DIM * ACC_W;
   localparam int RES_W   = OUT_DIM * OROW_W;

   localparam logic [2:0] CTRL_START = 3'd1;
   localparam logic [2:0] CTRL_NEXT  = 3'd2;
   localparam logic [2:0] CTRL_END   = 3'd0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COMPUTE,
      ST_RESULT,
      ST_WAIT,
      ST_DONE
   } state_e;

   typedef logic [ROW_W-1:0]        row_t;
   typedef logic signed [PIX_W-1:0] wgt_t;
   typedef logic [OROW_W-1:0]       orow_t;

endpackage

// File: rtl/ipf_if.sv
// Host-side command, load and result signals of the ipf engine.
// The host drives through master; the engine sits on slave.
interface ipf_if;
   import ipf_pkg::*;

   logic [2:0]       ctrl;
   logic             i_valid;
   row_t             i_data;
   logic             w_valid;
   logic [63:0]      w_data;
   logic             res_valid;
   logic [RES_W-1:0] res;
   logic             finish;

   modport master (
      output ctrl, i_valid, i_data, w_valid, w_data,
      input  res_valid, res, finish
   );

   modport slave (
      input  ctrl, i_valid, i_data, w_valid, w_data,
      output res_valid, res, finish
   );

endinterface

// File: rtl/ipf_row_mac.sv
// One output row of the convolution: three image rows in,
// six signed 32-bit sums out (9 taps per output column).
module ipf_row_mac
   import ipf_pkg::*;
(
   input  row_t  rows_i [K_DIM],
   input  wgt_t  w_i    [TAPS],
   output orow_t o_o
);

   for (genvar c = 0; c < OUT_DIM; c++) begin : g_col
      logic [PIX_W-1:0]        pix;
      logic signed [ACC_W-1:0] sum;

      // pixels are unsigned, so a zero MSB keeps them positive
      always_comb begin
         pix = '0;
         sum = '0;
         for (int t = 0; t < TAPS; t++) begin
            pix = rows_i[t/K_DIM][PIX_W*(c + t%K_DIM) +: PIX_W];
            sum = sum
                + ACC_W'($signed({1'b0, pix}))
                * ACC_W'(w_i[t]);
         end
      end

      assign o_o[ACC_W*c +: ACC_W] = sum;
   end

endmodule

// File: rtl/ipf.sv
// ipf top: image/weight storage, load counters, control FSM
// and the result buffer filled one output row per cycle.
module ipf
   import ipf_pkg::*;
#(
   parameter int In_Width   = 8,
   parameter int Out_Width  = 9,
   parameter int Addr_Width = 16
) (
   input  logic  clk,
   input  logic  rst,
   ipf_if.slave  bus
);

   if (In_Width != PIX_W || Out_Width != TAPS
       || Addr_Width < 1) begin : g_bad_cfg
      $error("ipf: only 8-bit data and 3x3 kernels supported");
   end

   state_e           st_q, st_d;
   row_t             img_q [IMG_DIM];
   wgt_t             w_q   [TAPS];
   logic [2:0]       icnt_q, icnt_d;
   logic [2:0]       rcnt_q, rcnt_d;
   logic             wcnt_q, wcnt_d;
   logic             iload_q, iload_d;
   logic             wload_q, wload_d;
   logic             fin_q, fin_d;
   logic             rv_q, rv_d;
   logic             img_we, w_we, buf_we, res_we;
   logic [RES_W-1:0] buf_q, res_q;
   row_t             win [K_DIM];
   orow_t            orow;

   for (genvar k = 0; k < K_DIM; k++) begin : g_win
      assign win[k] = img_q[3'(rcnt_q + k)];
   end

   ipf_row_mac u_mac (
      .rows_i (win),
      .w_i    (w_q),
      .o_o    (orow)
   );

   always_comb begin
      st_d    = st_q;
      icnt_d  = icnt_q;
      wcnt_d  = wcnt_q;
      rcnt_d  = rcnt_q;
      iload_d = iload_q;
      wload_d = wload_q;
      fin_d   = fin_q;
      rv_d    = 1'b0;
      img_we  = 1'b0;
      w_we    = 1'b0;
      buf_we  = 1'b0;
      res_we  = 1'b0;
      unique case (st_q)
         ST_IDLE: begin
            if (bus.i_valid) begin
               img_we = 1'b1;
               icnt_d = icnt_q + 3'd1;
               if (icnt_q == 3'd7) iload_d = 1'b1;
            end
            if (bus.w_valid) begin
               w_we   = 1'b1;
               wcnt_d = ~wcnt_q;
               if (wcnt_q) wload_d = 1'b1;
            end
            if (bus.ctrl == CTRL_START
                && iload_q && wload_q) begin
               st_d   = ST_COMPUTE;
               rcnt_d = '0;
            end else if (bus.ctrl == CTRL_END
                         && iload_q) begin
               st_d  = ST_DONE;
               fin_d = 1'b1;
            end
         end
         ST_COMPUTE: begin
            buf_we = 1'b1;
            rcnt_d = rcnt_q + 3'd1;
            if (rcnt_q == 3'(OUT_DIM - 1))
               st_d = ST_RESULT;
         end
         ST_RESULT: begin
            res_we = 1'b1;
            rv_d   = 1'b1;
            st_d   = ST_WAIT;
         end
         // a held START must not retrigger; only NEXT leaves
         ST_WAIT: begin
            if (bus.ctrl == CTRL_NEXT) begin
               st_d    = ST_IDLE;
               wload_d = 1'b0;
            end
         end
         ST_DONE: ;
         default: st_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q    <= ST_IDLE;
         icnt_q  <= '0;
         wcnt_q  <= 1'b0;
         rcnt_q  <= '0;
         iload_q <= 1'b0;
         wload_q <= 1'b0;
         fin_q   <= 1'b0;
         rv_q    <= 1'b0;
      end else begin
         st_q    <= st_d;
         icnt_q  <= icnt_d;
         wcnt_q  <= wcnt_d;
         rcnt_q  <= rcnt_d;
         iload_q <= iload_d;
         wload_q <= wload_d;
         fin_q   <= fin_d;
         rv_q    <= rv_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < IMG_DIM; r++)
            img_q[r] <= '0;
         for (int t = 0; t < TAPS; t++)
            w_q[t] <= '0;
         buf_q <= '0;
         res_q <= '0;
      end else begin
         if (img_we)
            img_q[icnt_q] <= bus.i_data;
         if (w_we) begin
            if (!wcnt_q) begin
               for (int t = 0; t < 8; t++)
                  w_q[t] <= bus.w_data[PIX_W*t +: PIX_W];
            end else begin
               w_q[TAPS-1] <= bus.w_data[PIX_W-1:0];
            end
         end
         if (buf_we)
            buf_q[OROW_W*int'(rcnt_q) +: OROW_W] <= orow;
         if (res_we)
            res_q <= buf_q;
      end
   end

   assign bus.res       = res_q;
   assign bus.res_valid = rv_q;
   assign bus.finish    = fin_q;

endmodule

// File: tb/tb_ipf.sv
// Bench for ipf: behavioural convolution/latency model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_ipf;
   import ipf_pkg::*;

   localparam logic [2:0] NOP = 3'd7;

   logic clk;
   logic rst;
   ipf_if bus ();

   ipf dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int img_buf [8][8];
   int w_buf   [9];

   int               m_pix [8][8];
   int               m_w   [9];
   int               m_mode, m_cd, m_ic, m_wc;
   bit               m_il, m_wl, m_valid, m_fin;
   logic [RES_W-1:0] m_res, m_snap;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_res(input string nm,
                          input logic [RES_W-1:0] act,
                          input logic [RES_W-1:0] exp);
      int k;
      tests++;
      if (act !== exp) begin
         fails++;
         k = -1;
         for (int i = 0; i < 36; i++)
            if (k < 0 && act[32*i +: 32] !== exp[32*i +: 32]) k = i;
         $display("FAIL %s: field %0d got %h want %h", nm, k,
                  act[32*k +: 32], exp[32*k +: 32]);
      end
   endtask

   // o(r,c) = sum p(r+i,c+j) * w(3i+j) in plain integers
   function automatic logic [RES_W-1:0] conv();
      logic [RES_W-1:0] v;
      int s;
      v = '0;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 6; c++) begin
            s = 0;
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  s += m_pix[r+i][c+j] * m_w[3*i+j];
            v[32*(6*r+c) +: 32] = s;
         end
      return v;
   endfunction

   task automatic m_reset();
      m_mode = 0; m_cd = 0; m_ic = 0; m_wc = 0;
      m_il = 0; m_wl = 0; m_valid = 0; m_fin = 0;
      m_res = '0; m_snap = '0;
   endtask

   // modes: 0 idle, 1 busy (result after 7 edges), 2 waiting, 3 done
   task automatic m_step();
      bit il, wl;
      il = m_il;
      wl = m_wl;
      m_valid = 0;
      case (m_mode)
         0: begin
            if (bus.i_valid) begin
               for (int c = 0; c < 8; c++)
                  m_pix[m_ic][c] = int'(bus.i_data[8*c +: 8]);
               if (m_ic == 7) m_il = 1;
               m_ic = (m_ic + 1) % 8;
            end
            if (bus.w_valid) begin
               if (m_wc == 0) begin
                  for (int k = 0; k < 8; k++)
                     m_w[k] = int'($signed(bus.w_data[8*k +: 8]));
               end else begin
                  m_w[8] = int'($signed(bus.w_data[7:0]));
                  m_wl = 1;
               end
               m_wc = 1 - m_wc;
            end
            if (bus.ctrl == 3'd1 && il && wl) begin
               m_snap = conv();
               m_cd = 7;
               m_mode = 1;
            end else if (bus.ctrl == 3'd0 && il) begin
               m_mode = 3;
               m_fin = 1;
            end
         end
         1: begin
            m_cd--;
            if (m_cd == 0) begin
               m_res = m_snap;
               m_valid = 1;
               m_mode = 2;
            end
         end
         2: if (bus.ctrl == 3'd2) begin
            m_mode = 0;
            m_wl = 0;
         end
         default: ;
      endcase
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) m_reset();
         else m_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("res_valid", 32'(bus.res_valid), 32'(m_valid));
         chk("finish", 32'(bus.finish), 32'(m_fin));
         chk_res("res", bus.res, m_res);
      end
   end

   function automatic logic [31:0] fld(input int r, input int c);
      return bus.res[32*(6*r+c) +: 32];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_img();
      for (int r = 0; r < 8; r++) begin
         bus.i_valid = 1'b1;
         for (int c = 0; c < 8; c++)
            bus.i_data[8*c +: 8] = 8'(img_buf[r][c]);
         step();
      end
      bus.i_valid = 1'b0;
   endtask

   task automatic load_w();
      bus.w_valid = 1'b1;
      for (int k = 0; k < 8; k++)
         bus.w_data[8*k +: 8] = 8'(w_buf[k]);
      step();
      bus.w_data = {56'd0, 8'(w_buf[8])};
      step();
      bus.w_valid = 1'b0;
   endtask

   task automatic cmd(input logic [2:0] v);
      bus.ctrl = v;
      step();
      bus.ctrl = NOP;
   endtask

   task automatic wait_pulse(input int maxc, output int lat);
      lat = -1;
      for (int k = 1; k <= maxc; k++) begin
         step();
         if (bus.res_valid) begin
            lat = k;
            break;
         end
      end
      tests++;
      if (lat < 0) begin
         fails++;
         $display("FAIL pulse_timeout: got none want pulse in %0d", maxc);
      end
   endtask

   task automatic run_start(output int lat);
      cmd(3'd1);
      wait_pulse(20, lat);
   endtask

   task automatic count_pulses(input int n, output int cnt);
      cnt = 0;
      for (int k = 0; k < n; k++) begin
         step();
         if (bus.res_valid) cnt++;
      end
   endtask

   task automatic fill_img(input int mode);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            case (mode)
               0: img_buf[r][c] = 1;
               1: img_buf[r][c] = 8*r + c;
               2: img_buf[r][c] = 255;
               default: img_buf[r][c] = (37*r + 11*c) % 256;
            endcase
   endtask

   task automatic fill_w(input int v);
      for (int k = 0; k < 9; k++) w_buf[k] = v;
   endtask

   int lat, n;
   logic [RES_W-1:0] e;

   initial begin
      rst = 1'b0;
      bus.ctrl = NOP;
      bus.i_valid = 1'b0;
      bus.i_data = '0;
      bus.w_valid = 1'b0;
      bus.w_data = '0;
      repeat (3) step();
      chk("rst_valid", 32'(bus.res_valid), 32'd0);
      chk("rst_finish", 32'(bus.finish), 32'd0);
      chk_res("rst_res", bus.res, '0);
      rst = 1'b1;
      step();

      // all ones
      fill_img(0); fill_w(1);
      load_img(); load_w();
      run_start(lat);
      chk("a_lat", lat, 7);
      for (int k = 0; k < 36; k++) e[32*k +: 32] = 32'd9;
      chk_res("a_all9", bus.res, e);
      cmd(3'd2);

      // identity kernel
      fill_img(1); fill_w(0); w_buf[4] = 1;
      load_img(); load_w();
      run_start(lat);
      chk("b_lat", lat, 7);
      chk("b_o00", fld(0, 0), 32'd9);
      chk("b_o55", fld(5, 5), 32'd54);
      chk("b_o23", fld(2, 3), 32'd28);
      cmd(3'd2);

      // max pixels, negative weight
      fill_img(2); fill_w(0); w_buf[0] = -1;
      load_img(); load_w();
      run_start(lat);
      chk("c_o00", fld(0, 0), 32'hFFFFFF01);
      chk("c_o55", fld(5, 5), 32'hFFFFFF01);
      chk("c_o32", fld(3, 2), 32'hFFFFFF01);
      cmd(3'd2);

      // START without weights, held START, second job, END
      fill_img(3);
      load_img();
      bus.ctrl = 3'd1;
      count_pulses(10, n);
      bus.ctrl = NOP;
      chk("d_no_w", n, 0);
      w_buf = '{3, -2, 1, 0, 5, -7, 2, 1, -1};
      load_w();
      bus.ctrl = 3'd1;
      count_pulses(20, n);
      bus.ctrl = NOP;
      chk("d_hold_one", n, 1);
      cmd(3'd2);
      w_buf = '{-128, 127, -1, 1, 0, 2, -3, 4, -5};
      load_w();
      bus.ctrl = 3'd1;
      count_pulses(10, n);
      bus.ctrl = NOP;
      chk("d_second", n, 1);
      cmd(3'd2);
      cmd(3'd0);
      chk("d_fin", 32'(bus.finish), 32'd1);
      bus.ctrl = 3'd1;
      count_pulses(10, n);
      bus.ctrl = NOP;
      chk("d_done_quiet", n, 0);
      chk("d_fin_sticky", 32'(bus.finish), 32'd1);

      // reset in the middle of a computation
      rst = 1'b0;
      step(); step();
      rst = 1'b1;
      fill_img(0); fill_w(1);
      load_img(); load_w();
      run_start(lat);
      chk("e_pre", fld(1, 1), 32'd9);
      cmd(3'd2);
      load_w();
      cmd(3'd1);
      step(); step();
      rst = 1'b0;
      step();
      chk_res("e_res0", bus.res, '0);
      chk("e_valid0", 32'(bus.res_valid), 32'd0);
      chk("e_fin0", 32'(bus.finish), 32'd0);
      count_pulses(4, n);
      rst = 1'b1;
      bus.ctrl = 3'd1;
      count_pulses(8, lat);
      bus.ctrl = NOP;
      chk("e_no_pulse", n + lat, 0);
      fill_w(2);
      load_img(); load_w();
      run_start(lat);
      chk("e_lat", lat, 7);
      chk("e_o22", fld(2, 2), 32'd18);
      step(); step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
